// File: rtl/wshb_frame_responder.sv
// Wishbone B4 responder backed by on-chip synchronous RAM.
// Serves classic cycles and linear incrementing bursts with registered-feedback
// timing: the next word index is predicted, the RAM is read at that predicted
// index and the data is registered, so a sustained burst acks one beat per clock.
`timescale 1ns/1ps

module wshb_frame_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    input  logic [3:0]  sel,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic [31:0] dat_sm,
    output logic        ack,
    output logic        err,
    output logic        rty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [2:0]    CTI_INCR  = 3'b010;
    localparam logic [2:0]    CTI_END   = 3'b111;
    localparam logic [29:0]   BASE_WIDX = BASE_ADDR[31:2];
    localparam logic [PW-1:0] P_END     = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLASSIC = 2'd1,
        ST_BURST   = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    state_t        state_r;
    logic [PW-1:0] p_r;
    logic [PW-1:0] p_nxt_s;
    logic [PW-1:0] p_inc_s;
    logic          ack_q_r;
    logic          err_r;
    logic [31:0]   dat_sm_r;
    logic [31:0]   mem_r [DEPTH];

    logic [29:0]   adr_widx_s;
    logic          in_range_s;
    logic          match_s;
    logic          ack_s;
    logic          last_s;
    logic          req_bad_s;
    logic          adr_lsb_unused_s;

    // Address decode: word index relative to the base, range check and match
    // against the predicted index.
    assign adr_widx_s       = adr[31:2] - BASE_WIDX;
    assign in_range_s       = (adr[31:2] >= BASE_WIDX) && (adr_widx_s < 30'(DEPTH));
    assign match_s          = in_range_s && (adr_widx_s == 30'(p_r));
    assign adr_lsb_unused_s = ^adr[1:0];

    assign p_inc_s   = p_r + PW'(1);
    assign last_s    = (p_inc_s == P_END);
    assign req_bad_s = !in_range_s || ((cti == CTI_INCR) && (bte != 2'b00));

    // A beat is only acknowledged when the master presents the predicted word.
    assign ack_s  = ack_q_r & cyc & stb & match_s;
    assign ack    = ack_s;
    assign err    = err_r & cyc;
    assign rty    = 1'b0;
    assign dat_sm = dat_sm_r;

    // Predicted word index for the next cycle; also addresses the RAM read port.
    always_comb begin
        p_nxt_s = p_r;
        if (cyc) begin
            case (state_r)
                ST_IDLE: begin
                    if (stb && !req_bad_s) begin
                        p_nxt_s = adr_widx_s[PW-1:0];
                    end else begin
                        p_nxt_s = p_r;
                    end
                end
                ST_BURST: begin
                    if (ack_s && (cti != CTI_END) && !last_s) begin
                        p_nxt_s = p_inc_s;
                    end else if (stb && !match_s && in_range_s) begin
                        // Master jumped (e.g. wrapped): re-aim at its address.
                        p_nxt_s = adr_widx_s[PW-1:0];
                    end else begin
                        p_nxt_s = p_r;
                    end
                end
                default: begin
                    p_nxt_s = p_r;
                end
            endcase
        end else begin
            p_nxt_s = p_r;
        end
    end

    // Bus FSM: state, pending-ack flag, error strobe and predicted index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ack_q_r <= 1'b0;
            err_r   <= 1'b0;
            p_r     <= {PW{1'b0}};
        end else begin
            p_r <= p_nxt_s;
            if (!cyc) begin
                state_r <= ST_IDLE;
                ack_q_r <= 1'b0;
                err_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (stb && req_bad_s) begin
                            ack_q_r <= 1'b0;
                            err_r   <= 1'b1;
                            state_r <= ST_ERR;
                        end else if (stb) begin
                            ack_q_r <= 1'b1;
                            err_r   <= 1'b0;
                            state_r <= (cti == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                        end else begin
                            ack_q_r <= 1'b0;
                            err_r   <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_CLASSIC: begin
                        // Single beat done; force one idle cycle before the next request.
                        ack_q_r <= 1'b0;
                        err_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    ST_BURST: begin
                        if (ack_s && (cti == CTI_END)) begin
                            ack_q_r <= 1'b0;
                            err_r   <= 1'b0;
                            state_r <= ST_IDLE;
                        end else if (ack_s && last_s) begin
                            ack_q_r <= 1'b0;
                            err_r   <= 1'b1;
                            state_r <= ST_ERR;
                        end else if (stb && !match_s && !in_range_s) begin
                            ack_q_r <= 1'b0;
                            err_r   <= 1'b1;
                            state_r <= ST_ERR;
                        end else begin
                            ack_q_r <= 1'b1;
                            err_r   <= 1'b0;
                            state_r <= ST_BURST;
                        end
                    end
                    ST_ERR: begin
                        ack_q_r <= 1'b0;
                        err_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        ack_q_r <= 1'b0;
                        err_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // RAM write port: byte-lane write of the acknowledged beat.
    always_ff @(posedge clk) begin
        if (!rst && ack_s && we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    mem_r[p_r[AW-1:0]][8*b +: 8] <= dat_ms[8*b +: 8];
                end
            end
        end
    end

    // RAM read port: registered data at the predicted index for the next beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_sm_r <= 32'h0000_0000;
        end else begin
            dat_sm_r <= mem_r[p_nxt_s[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_wshb_frame_responder.sv
// Self-checking bench for wshb_frame_responder: a bus driver pushes the expected
// response stream (kind, cycle, read data) computed from a word-array model of
// the RAM; a monitor pops and compares each ack/err the DUT presents.
`timescale 1ns/1ps

module tb_wshb_frame_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [31:0] adr, dat_ms, dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;

    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wr_dat [DEPTH];
    logic [3:0]  wr_sel [DEPTH];
    int          cyc_cnt  = 0;
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    wshb_frame_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
        .dat_ms(dat_ms), .sel(sel), .cti(cti), .bte(bte),
        .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc_cnt);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic push_exp(input bit is_err, input bit chk, input logic [31:0] d, input int c);
        exp_t e;
        e.is_err = is_err; e.chk_dat = chk; e.dat = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every response the DUT shows must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (ack || err)) begin
            check("ack_err_exclusive", 32'(ack & err), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {30'd0, ack, err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_kind_err", 32'(err), 32'(mon_e.is_err));
                check("resp_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
                if (mon_e.chk_dat && ack) check("rd_data", dat_sm, mon_e.dat);
            end
        end
    end

    // Single (classic) transfer; optional hold of stb one cycle past the ack.
    task automatic classic(input logic [31:0] a, input bit wr, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                           input bit hold);
        int t0, wi, cycles;
        bit ok, got;
        @(posedge clk); #1;
        t0 = cyc_cnt;
        wi = int'((a - BASE) >> 2);
        ok = (a >= BASE) && (wi < DEPTH) && !((c == 3'b010) && (b != 2'b00));
        if (ok) begin
            push_exp(1'b0, !wr, model_mem[wi], t0 + 1);
            if (wr) model_mem[wi] = merge(model_mem[wi], d, s);
        end else begin
            push_exp(1'b1, 1'b0, 32'd0, t0 + 1);
        end
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_ms = d; sel = s; cti = c; bte = b;
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 8) begin
            @(negedge clk);
            got = ack || err;
            cycles++;
            @(posedge clk); #1;
        end
        if (!got) check("classic_timeout", 32'(got), 32'd1);
        if (hold) begin
            @(negedge clk);
            check("classic_gap", {30'd0, ack, err}, 32'd0);
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Incrementing burst of n beats starting at word start. Optional master
    // stall before beat stall_beat, address jump to wrap_to at wrap_beat, and
    // reset abort after abort_after acks. Write data comes from wr_dat/wr_sel.
    task automatic burst(input int start, input int n, input bit wr,
                         input int stall_beat, input int stall_len,
                         input int wrap_beat, input int wrap_to, input int abort_after);
        int t0, prev, tnext, w, k, cycles, stall_left;
        bit stalled, wrapped, done;
        @(posedge clk); #1;
        t0 = cyc_cnt;
        // Expected response stream from the burst rules.
        w = start;
        prev = t0;
        for (int j = 0; j < n; j++) begin
            if (abort_after >= 0 && j >= abort_after) break;
            if (j > 0 && w >= DEPTH) begin
                push_exp(1'b1, 1'b0, 32'd0, prev + 1);
                break;
            end
            tnext = (j == 0) ? t0 + 1 : prev + 1;
            if (j == stall_beat) tnext += stall_len;
            if (j == wrap_beat && wrap_to != w) tnext += 1;
            if (j == wrap_beat) w = wrap_to;
            push_exp(1'b0, !wr, model_mem[w], tnext);
            if (wr) model_mem[w] = merge(model_mem[w], wr_dat[j], wr_sel[j]);
            prev = tnext;
            w++;
        end
        // Drive the bus, reacting to the DUT's ack/err.
        k = 0; w = start; stalled = 0; wrapped = 0; done = 0; stall_left = 0; cycles = 0;
        while (!done) begin
            if (k == stall_beat && !stalled) begin stalled = 1; stall_left = stall_len; end
            if (k == wrap_beat && !wrapped) begin wrapped = 1; w = wrap_to; end
            cyc = 1'b1; we = wr; bte = 2'b00;
            if (stall_left > 0) begin
                stb = 1'b0;
                stall_left--;
            end else begin
                stb = 1'b1;
                adr = BASE + 32'(w) * 32'd4;
                cti = (k == n - 1) ? 3'b111 : 3'b010;
                dat_ms = wr_dat[k];
                sel = wr_sel[k];
            end
            @(negedge clk);
            if (err) begin
                done = 1;
            end else if (ack) begin
                k++; w++;
                if (k == n) begin
                    done = 1;
                end else if (k == abort_after) begin
                    done = 1;
                    @(posedge clk); #1;
                    rst = 1'b1; stb = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0; stb = 1'b1; we = 1'b0;
                    adr = BASE + 32'(w) * 32'd4; cti = 3'b010;
                    @(negedge clk);
                    check("post_rst_ack", 32'(ack), 32'd0);
                    check("post_rst_err", 32'(err), 32'd0);
                end
            end
            cycles++;
            if (!done && cycles > n * 4 + 16) begin
                check("burst_timeout", 32'(k), 32'(n));
                done = 1;
            end
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rand_wdata(input int n);
        for (int i = 0; i < n; i++) begin
            wr_dat[i] = $urandom;
            wr_sel[i] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, n, sb, wb;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0;
        dat_ms = 32'd0; sel = 4'd0; cti = 3'd0; bte = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dat", dat_sm, 32'd0);
        check("rty_zero", 32'(rty), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill the whole RAM with one full-length write burst.
        for (int i = 0; i < DEPTH; i++) begin
            wr_dat[i] = $urandom;
            wr_sel[i] = 4'hF;
        end
        wr_dat[4] = 32'hCAFE_0004;
        wr_dat[2] = 32'hFFFF_FFFF;
        burst(0, DEPTH, 1'b1, -1, 0, -1, 0, -1);

        // Classic read with stb held past the ack.
        classic(32'h10, 1'b0, 32'd0, 4'h0, 3'b000, 2'b00, 1'b1);
        // Partial-lane classic write then read back.
        classic(32'h8, 1'b1, 32'h1122_3344, 4'b0101, 3'b000, 2'b00, 1'b0);
        classic(32'h8, 1'b0, 32'd0, 4'h0, 3'b001, 2'b00, 1'b0);
        check("lane_merge_model", model_mem[2], 32'hFF22_FF44);

        // 16-beat burst read, then stall at beat 5 and wrap to 0 at beat 10.
        burst(0, 16, 1'b0, -1, 0, -1, 0, -1);
        burst(0, 16, 1'b0, 5, 3, 10, 0, -1);

        // Out-of-range single, burst running off the end, unsupported bte.
        classic(DEPTH * 4, 1'b0, 32'd0, 4'h0, 3'b000, 2'b00, 1'b0);
        burst(DEPTH - 2, 4, 1'b0, -1, 0, -1, 0, -1);
        classic(32'h20, 1'b0, 32'd0, 4'h0, 3'b010, 2'b01, 1'b0);

        // Byte-lane write burst followed by a read burst over the same words.
        rand_wdata(8);
        burst(100, 8, 1'b1, -1, 0, -1, 0, -1);
        burst(100, 8, 1'b0, -1, 0, -1, 0, -1);

        // Reset mid-burst, then a normal classic read.
        burst(20, 10, 1'b0, -1, 0, -1, 0, 4);
        classic(32'h40, 1'b0, 32'd0, 4'h0, 3'b000, 2'b00, 1'b0);

        // Randomized mix of classic and burst traffic.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    classic(BASE + 32'($urandom_range(DEPTH, DEPTH + 1000)) * 32'd4, 1'b0,
                            32'd0, 4'h0, 3'b000, 2'b00, 1'b0);
                else
                    classic(BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4,
                            1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                            3'($urandom_range(0, 1)), 2'b00, 1'($urandom_range(0, 1)));
            end else begin
                st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 12, DEPTH - 1))
                                                 : int'($urandom_range(0, DEPTH - 20));
                n  = int'($urandom_range(1, 12));
                sb = (n > 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1;
                wb = (n > 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1;
                rand_wdata(n);
                burst(st, n, 1'($urandom_range(0, 1)), sb, int'($urandom_range(1, 3)),
                      wb, int'($urandom_range(0, DEPTH - 1)), -1);
            end
        end

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
